// File: rtl/sparam_pkg.sv
// Shared types and sizing helpers for the S-parameter sweep sequencer.
package sparam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACQ,
        EMIT,
        FINISH
    } state_e;

    // Default build: 4-port coupler, 12-bit detector, 8-sample mean, 16-cycle settle.
    localparam int unsigned NPORTS_DEF     = 4;
    localparam int unsigned ADC_W_DEF      = 12;
    localparam int unsigned AVG_LOG2_DEF   = 3;
    localparam int unsigned SETTLE_CYC_DEF = 16;
    localparam int unsigned IDX_W_DEF      = $clog2(NPORTS_DEF);
    localparam int unsigned ACC_W_DEF      = ADC_W_DEF + AVG_LOG2_DEF;

    // Port index width; a single-port build still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sum of 2^avg_log2 samples of adc_w bits can never overflow this width.
    function automatic int unsigned acc_width(input int unsigned adc_w,
                                              input int unsigned avg_log2);
        return adc_w + avg_log2;
    endfunction

endpackage

// File: rtl/sparam_avg_accum.sv
// NPORTS parallel sample accumulators with synchronous clear and truncating-mean outputs.
module sparam_avg_accum
    import sparam_pkg::*;
#(
    parameter int unsigned NPORTS   = NPORTS_DEF,
    parameter int unsigned ADC_W    = ADC_W_DEF,
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic [NPORTS*ADC_W-1:0] i_data,
    output logic [NPORTS*ADC_W-1:0] o_mean
);

    localparam int unsigned ACC_W = acc_width(ADC_W, AVG_LOG2);

    logic [ACC_W-1:0] r_acc [NPORTS];

    // Clear wins over enable; each channel sums into its own register.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            for (int j = 0; j < NPORTS; j++) begin
                r_acc[j] <= '0;
            end
        end else if (i_en) begin
            for (int j = 0; j < NPORTS; j++) begin
                r_acc[j] <= r_acc[j] + ACC_W'(i_data[j*ADC_W +: ADC_W]);
            end
        end
    end

    // Mean is the sum with the low AVG_LOG2 bits dropped (no rounding).
    for (genvar j = 0; j < NPORTS; j++) begin : g_mean
        assign o_mean[j*ADC_W +: ADC_W] = r_acc[j][AVG_LOG2 +: ADC_W];
    end

endmodule

// File: rtl/sparam_sweep_seq.sv
// Sweep sequencer: excites each port in turn, settles, averages all receive ports,
// then streams one |S[rx,tx]| word per matrix entry.
module sparam_sweep_seq
    import sparam_pkg::*;
#(
    parameter int unsigned NPORTS     = NPORTS_DEF,
    parameter int unsigned ADC_W      = ADC_W_DEF,
    parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [NPORTS-1:0]            o_port_sel,
    input  logic                         i_adc_valid,
    input  logic [NPORTS*ADC_W-1:0]      i_adc_data,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [idx_width(NPORTS)-1:0] o_res_tx,
    output logic [idx_width(NPORTS)-1:0] o_res_rx,
    output logic [ADC_W-1:0]             o_res_mag
);

    localparam int unsigned IDX_W = idx_width(NPORTS);
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPORTS - 1);
    localparam logic [CNT_W-1:0] LAST_SMP  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC);
    localparam state_e           ARM_ST    = (SETTLE_CYC == 0) ? ACQ : SETTLE;

    state_e                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_tx, w_tx_nxt;
    logic [IDX_W-1:0]        r_rx, w_rx_nxt;
    logic [SET_W-1:0]        r_settle, w_settle_nxt;
    logic [CNT_W-1:0]        r_smp, w_smp_nxt;
    logic                    w_acc_clr;
    logic                    w_acc_en;
    logic [NPORTS*ADC_W-1:0] w_mean;

    sparam_avg_accum #(
        .NPORTS   (NPORTS),
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_acc_clr),
        .i_en   (w_acc_en),
        .i_data (i_adc_data),
        .o_mean (w_mean)
    );

    // State and counter registers; reset abandons any partial sweep.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_tx     <= '0;
            r_rx     <= '0;
            r_settle <= '0;
            r_smp    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx     <= w_tx_nxt;
            r_rx     <= w_rx_nxt;
            r_settle <= w_settle_nxt;
            r_smp    <= w_smp_nxt;
        end
    end

    // Next-state, counter updates and accumulator control.
    always_comb begin
        w_state_nxt  = r_state;
        w_tx_nxt     = r_tx;
        w_rx_nxt     = r_rx;
        w_settle_nxt = r_settle;
        w_smp_nxt    = r_smp;
        w_acc_clr    = 1'b0;
        w_acc_en     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_tx_nxt     = '0;
                    w_rx_nxt     = '0;
                    w_smp_nxt    = '0;
                    w_settle_nxt = SETTLE_LD;
                    w_acc_clr    = 1'b1;
                    w_state_nxt  = ARM_ST;
                end
            end
            SETTLE: begin
                w_settle_nxt = r_settle - 1'b1;
                if (r_settle <= SET_W'(1)) begin
                    w_state_nxt = ACQ;
                end
            end
            ACQ: begin
                if (i_adc_valid) begin
                    w_acc_en  = 1'b1;
                    w_smp_nxt = r_smp + 1'b1;
                    if (r_smp == LAST_SMP) begin
                        w_smp_nxt   = '0;
                        w_rx_nxt    = '0;
                        w_state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (i_res_ready) begin
                    if (r_rx == LAST_IDX) begin
                        w_rx_nxt = '0;
                        if (r_tx == LAST_IDX) begin
                            w_state_nxt = FINISH;
                        end else begin
                            w_tx_nxt     = r_tx + 1'b1;
                            w_settle_nxt = SETTLE_LD;
                            w_acc_clr    = 1'b1;
                            w_state_nxt  = ARM_ST;
                        end
                    end else begin
                        w_rx_nxt = r_rx + 1'b1;
                    end
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs: source drive only while settling/acquiring, result mux in EMIT.
    always_comb begin
        o_busy      = (r_state == SETTLE) || (r_state == ACQ) || (r_state == EMIT);
        o_done      = (r_state == FINISH);
        o_port_sel  = '0;
        if ((r_state == SETTLE) || (r_state == ACQ)) begin
            o_port_sel = NPORTS'(1) << r_tx;
        end
        o_res_valid = (r_state == EMIT);
        o_res_tx    = r_tx;
        o_res_rx    = r_rx;
        o_res_mag   = '0;
        if (r_state == EMIT) begin
            o_res_mag = w_mean[int'(r_rx)*ADC_W +: ADC_W];
        end
    end

endmodule

// File: tb/tb_sparam_sweep_seq.sv
// Self-checking bench: table of randomized sweeps against a queue-based model,
// plus hand sequences for reset mid-sweep and the zero-settle build.
module tb_sparam_sweep_seq;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int SC = 16;
    localparam int NS = 8;

    typedef struct {
        int tx;
        int rx;
        int mag;
    } res_t;

    typedef struct {
        int dm;       // data pattern: 0 const 100, 1 per-tx, 2 truncation/full-scale, 3 random
        int vm;       // adc_valid: 0 always, 1 every 3rd cycle, 2 random
        int rm;       // res_ready: 0 always, 1 toggling, 2 random
        bit bstart;   // throw stray start pulses while busy
        int exp_lat;  // expected done latency in cycles after start edge, -1 = don't care
        int exp_res;  // expected number of accepted results
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, adc_valid, res_ready;
    logic [NP*AW-1:0] adc_data;
    logic            busy, done, res_valid;
    logic [NP-1:0]   port_sel;
    logic [1:0]      res_tx, res_rx;
    logic [AW-1:0]   res_mag;

    logic            rst_z, start_z, adc_valid_z, res_ready_z;
    logic [NP*AW-1:0] adc_data_z;
    logic            busy_z, done_z, res_valid_z;
    logic [NP-1:0]   port_sel_z;
    logic [1:0]      res_tx_z, res_rx_z;
    logic [AW-1:0]   res_mag_z;

    sparam_sweep_seq #(.NPORTS(NP), .ADC_W(AW), .AVG_LOG2(3), .SETTLE_CYC(SC)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .o_port_sel(port_sel), .i_adc_valid(adc_valid), .i_adc_data(adc_data),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_tx(res_tx),
        .o_res_rx(res_rx), .o_res_mag(res_mag)
    );

    sparam_sweep_seq #(.NPORTS(NP), .ADC_W(AW), .AVG_LOG2(3), .SETTLE_CYC(0)) dut_z (
        .i_clk(clk), .i_rst(rst_z), .i_start(start_z), .o_busy(busy_z), .o_done(done_z),
        .o_port_sel(port_sel_z), .i_adc_valid(adc_valid_z), .i_adc_data(adc_data_z),
        .o_res_valid(res_valid_z), .i_res_ready(res_ready_z), .o_res_tx(res_tx_z),
        .o_res_rx(res_rx_z), .o_res_mag(res_mag_z)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP*AW-1:0] garbage();
        logic [NP*AW-1:0] d;
        for (int j = 0; j < NP; j++) d[j*AW +: AW] = AW'($urandom);
        return d;
    endfunction

    // One full sweep. The model tracks, in plain counts, how long the source has been on
    // for the current tx, which samples fall after the settle window, and the results
    // those samples must produce.
    task automatic run_sweep(input int dm, input int vm, input int rm, input bit bstart,
                             input bit abort, output int latency, output int n_res);
        int m_tx, m_age, m_cnt, cyc, v;
        int m_sum[NP];
        bit m_active, m_done_exp, m_busy_exp, finished;
        res_t exp_q[$];
        res_t r;
        latency = -1;
        n_res   = 0;
        start     = 1'b1;
        adc_valid = 1'(($urandom % 2));
        adc_data  = garbage();
        res_ready = 1'b1;
        step();
        start = 1'b0;
        m_tx = 0; m_age = 0; m_cnt = 0; cyc = 0;
        m_active = 1; m_busy_exp = 1; m_done_exp = 0; finished = 0;
        for (int j = 0; j < NP; j++) m_sum[j] = 0;
        while (!finished && cyc < 3000) begin
            chk("busy", 32'(busy), 32'(m_busy_exp));
            chk("done", 32'(done), 32'(m_done_exp));
            chk("port_sel", 32'(port_sel), m_active ? (32'd1 << m_tx) : 32'd0);
            chk("res_valid", 32'(res_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("res_tx", 32'(res_tx), 32'(exp_q[0].tx));
                chk("res_rx", 32'(res_rx), 32'(exp_q[0].rx));
                chk("res_mag", 32'(res_mag), 32'(exp_q[0].mag));
            end
            if (m_done_exp) begin
                latency = cyc;
                start = 1'b1;  // coincides with done: must be ignored
                step();
                start = 1'b0;
                chk("post_done_busy", 32'(busy), 32'd0);
                chk("post_done_port_sel", 32'(port_sel), 32'd0);
                chk("post_done_done", 32'(done), 32'd0);
                step();
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_res_valid", 32'(res_valid), 32'd0);
                finished = 1;
            end else if (abort && m_active && m_tx == 2 && m_age > SC && m_cnt >= 2) begin
                rst = 1'b1;
                start = 1'b0;
                step();
                rst = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_port_sel", 32'(port_sel), 32'd0);
                chk("abort_res_valid", 32'(res_valid), 32'd0);
                for (int k = 0; k < 20; k++) begin
                    chk("abort_no_done", 32'(done), 32'd0);
                    step();
                end
                finished = 1;
            end else begin
                start = bstart && (($urandom % 5) == 0);
                case (vm)
                    0: adc_valid = 1'b1;
                    1: adc_valid = ((cyc % 3) == 0);
                    default: adc_valid = 1'(($urandom % 2));
                endcase
                case (rm)
                    0: res_ready = 1'b1;
                    1: res_ready = ((cyc % 2) == 0);
                    default: res_ready = 1'(($urandom % 2));
                endcase
                adc_data = garbage();
                if (m_active && m_age + 1 > SC) begin
                    for (int j = 0; j < NP; j++) begin
                        case (dm)
                            0: v = 100;
                            1: v = 10 * (m_tx + 1) + j;
                            2: v = (j == 0) ? ((m_cnt == NS - 1) ? 7 : 0) : 4095;
                            default: v = int'($urandom % 4096);
                        endcase
                        adc_data[j*AW +: AW] = AW'(v);
                    end
                end
                if (m_active) begin
                    m_age++;
                    if (m_age > SC && adc_valid) begin
                        for (int j = 0; j < NP; j++) m_sum[j] += int'(adc_data[j*AW +: AW]);
                        m_cnt++;
                        if (m_cnt == NS) begin
                            for (int j = 0; j < NP; j++) begin
                                r.tx = m_tx; r.rx = j; r.mag = m_sum[j] / NS;
                                exp_q.push_back(r);
                            end
                            m_active = 0;
                        end
                    end
                end else if (exp_q.size() > 0 && res_ready) begin
                    void'(exp_q.pop_front());
                    n_res++;
                    if (exp_q.size() == 0) begin
                        if (m_tx < NP - 1) begin
                            m_tx++; m_active = 1; m_age = 0; m_cnt = 0;
                            for (int j = 0; j < NP; j++) m_sum[j] = 0;
                        end else begin
                            m_done_exp = 1;
                            m_busy_exp = 0;
                        end
                    end
                end
                step();
                cyc++;
            end
        end
        chk("sweep_terminated", 32'(finished), 32'd1);
        start = 1'b0;
        adc_valid = 1'b0;
    endtask

    vec_t vecs[7];
    int lat, nres;

    initial begin
        vecs[0] = '{dm: 0, vm: 0, rm: 0, bstart: 0, exp_lat: 112, exp_res: 16};
        vecs[1] = '{dm: 1, vm: 0, rm: 0, bstart: 1, exp_lat: 112, exp_res: 16};
        vecs[2] = '{dm: 2, vm: 0, rm: 0, bstart: 0, exp_lat: 112, exp_res: 16};
        vecs[3] = '{dm: 1, vm: 0, rm: 1, bstart: 0, exp_lat: -1,  exp_res: 16};
        vecs[4] = '{dm: 1, vm: 1, rm: 0, bstart: 0, exp_lat: -1,  exp_res: 16};
        vecs[5] = '{dm: 3, vm: 2, rm: 2, bstart: 1, exp_lat: -1,  exp_res: 16};
        vecs[6] = '{dm: 3, vm: 1, rm: 2, bstart: 1, exp_lat: -1,  exp_res: 16};

        rst = 1'b1; start = 1'b0; adc_valid = 1'b0; adc_data = '0; res_ready = 1'b0;
        rst_z = 1'b1; start_z = 1'b0; adc_valid_z = 1'b0; adc_data_z = '0; res_ready_z = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_port_sel", 32'(port_sel), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_tx", 32'(res_tx), 32'd0);
        chk("rst_res_rx", 32'(res_rx), 32'd0);
        chk("rst_res_mag", 32'(res_mag), 32'd0);
        chk("rst_z_busy", 32'(busy_z), 32'd0);
        rst = 1'b0;
        rst_z = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_sweep(vecs[i].dm, vecs[i].vm, vecs[i].rm, vecs[i].bstart, 1'b0, lat, nres);
            if (vecs[i].exp_lat >= 0) chk("done_latency", 32'(lat), 32'(vecs[i].exp_lat));
            chk("result_count", 32'(nres), 32'(vecs[i].exp_res));
            step();
        end

        // Reset during tx=2 acquisition, then a clean sweep must still be correct.
        run_sweep(1, 0, 0, 1'b0, 1'b1, lat, nres);
        chk("abort_result_count", 32'(nres), 32'd8);
        run_sweep(1, 2, 2, 1'b0, 1'b0, lat, nres);
        chk("after_abort_results", 32'(nres), 32'd16);

        // Zero-settle build: start sample ignored, acquisition begins next cycle.
        start_z = 1'b1;
        adc_valid_z = 1'b1;
        for (int j = 0; j < NP; j++) adc_data_z[j*AW +: AW] = AW'(9);
        step();
        start_z = 1'b0;
        chk("z_busy", 32'(busy_z), 32'd1);
        chk("z_port_sel", 32'(port_sel_z), 32'd1);
        for (int k = 1; k <= NS; k++) begin
            for (int j = 0; j < NP; j++) adc_data_z[j*AW +: AW] = AW'(k);
            step();
            if (k < NS) chk("z_res_valid_early", 32'(res_valid_z), 32'd0);
        end
        chk("z_res_valid", 32'(res_valid_z), 32'd1);
        chk("z_res_mag", 32'(res_mag_z), 32'd4);
        chk("z_res_tx", 32'(res_tx_z), 32'd0);
        chk("z_res_rx", 32'(res_rx_z), 32'd0);
        chk("z_port_sel_emit", 32'(port_sel_z), 32'd0);
        adc_valid_z = 1'b0;
        rst_z = 1'b1;
        step();
        rst_z = 1'b0;
        chk("z_rst_res_valid", 32'(res_valid_z), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
